// File: rtl/process_quantum_scheduler.sv
// Preemptive round-robin quantum scheduler: counts retired user instructions and
// raises a kernel swap request on quantum expiry or a HALT / ROUND_ROBIN retire.
module process_quantum_scheduler #(
  parameter int QUANTUM = 32,
  parameter int PID_W   = 4,
  parameter int CNT_W   = $clog2(QUANTUM + 1)
) (
  input  logic             i_clock,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_instr_valid,
  input  logic [5:0]       i_opcode,
  input  logic             i_pid_wr,
  input  logic [PID_W-1:0] i_pid_data,
  input  logic             i_swap_ack,
  output logic             o_swap_req,
  output logic [1:0]       o_swap_cause,
  output logic [PID_W-1:0] o_current_pid,
  output logic [PID_W-1:0] o_saved_pid,
  output logic [CNT_W-1:0] o_quantum_left,
  output logic [15:0]      o_swap_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_REQ  = 2'd2
  } state_t;

  localparam logic [5:0]       OP_HALT   = 6'b011001;
  localparam logic [5:0]       OP_RR     = 6'b011011;
  localparam logic [1:0]       CAUSE_Q   = 2'b00;
  localparam logic [1:0]       CAUSE_HLT = 2'b01;
  localparam logic [1:0]       CAUSE_RR  = 2'b10;
  localparam logic [CNT_W-1:0] Q_FULL    = CNT_W'(QUANTUM);
  localparam logic [CNT_W-1:0] Q_ONE     = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_nxt;
  logic [PID_W-1:0] r_cur_pid;
  logic [PID_W-1:0] w_cur_pid_nxt;
  logic [PID_W-1:0] r_saved_pid;
  logic [PID_W-1:0] w_saved_pid_nxt;
  logic [CNT_W-1:0] r_qleft;
  logic [CNT_W-1:0] w_qleft_nxt;
  logic [15:0]      r_swap_cnt;
  logic [15:0]      w_swap_cnt_nxt;
  logic             r_swap_req;
  logic             w_pid_go;

  // A SET_PID commit arms the slice only when preemption is enabled and the PID is a user process.
  assign w_pid_go = i_enable && (i_pid_data != '0);

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cause_nxt     = r_cause;
    w_cur_pid_nxt   = r_cur_pid;
    w_saved_pid_nxt = r_saved_pid;
    w_qleft_nxt     = r_qleft;
    w_swap_cnt_nxt  = r_swap_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_pid_wr) begin
          w_cur_pid_nxt = i_pid_data;
          w_qleft_nxt   = Q_FULL;
          if (w_pid_go) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Reload beats disarm, which beats retirement accounting.
        if (i_pid_wr) begin
          w_cur_pid_nxt = i_pid_data;
          w_qleft_nxt   = Q_FULL;
          w_state_nxt   = w_pid_go ? S_RUN : S_IDLE;
        end else if (!i_enable) begin
          w_qleft_nxt = Q_FULL;
          w_state_nxt = S_IDLE;
        end else if (i_instr_valid) begin
          if (i_opcode == OP_HALT) begin
            w_cause_nxt = CAUSE_HLT;
            w_state_nxt = S_REQ;
          end else if (i_opcode == OP_RR) begin
            w_cause_nxt = CAUSE_RR;
            w_state_nxt = S_REQ;
          end else begin
            w_qleft_nxt = r_qleft - Q_ONE;
            if (r_qleft == Q_ONE) begin
              w_cause_nxt = CAUSE_Q;
              w_state_nxt = S_REQ;
            end
          end
        end
      end
      S_REQ: begin
        if (i_swap_ack) begin
          w_saved_pid_nxt = r_cur_pid;
          w_cur_pid_nxt   = '0;
          w_qleft_nxt     = Q_FULL;
          w_swap_cnt_nxt  = r_swap_cnt + 16'd1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output registers; swap_req is a dedicated flop so the handshake line is glitch-free.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_swap_req  <= 1'b0;
      r_cause     <= CAUSE_Q;
      r_cur_pid   <= '0;
      r_saved_pid <= '0;
      r_qleft     <= Q_FULL;
      r_swap_cnt  <= '0;
    end else begin
      r_swap_req  <= (w_state_nxt == S_REQ);
      r_cause     <= w_cause_nxt;
      r_cur_pid   <= w_cur_pid_nxt;
      r_saved_pid <= w_saved_pid_nxt;
      r_qleft     <= w_qleft_nxt;
      r_swap_cnt  <= w_swap_cnt_nxt;
    end
  end

  assign o_swap_req     = r_swap_req;
  assign o_swap_cause   = r_cause;
  assign o_current_pid  = r_cur_pid;
  assign o_saved_pid    = r_saved_pid;
  assign o_quantum_left = r_qleft;
  assign o_swap_count   = r_swap_cnt;

endmodule

// File: tb/tb_process_quantum_scheduler.sv
// Directed bench for process_quantum_scheduler: a behavioural scheduler model checked
// every cycle, plus hand-computed expectations at the scenario milestones.
module tb_process_quantum_scheduler;

  localparam int QUANTUM = 32;
  localparam int PID_W   = 4;
  localparam int CNT_W   = $clog2(QUANTUM + 1);

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             instr_valid;
  logic [5:0]       opcode;
  logic             pid_wr;
  logic [PID_W-1:0] pid_data;
  logic             swap_ack;
  logic             swap_req;
  logic [1:0]       swap_cause;
  logic [PID_W-1:0] current_pid;
  logic [PID_W-1:0] saved_pid;
  logic [CNT_W-1:0] quantum_left;
  logic [15:0]      swap_count;

  int checks = 0;
  int errors = 0;

  process_quantum_scheduler #(.QUANTUM(QUANTUM), .PID_W(PID_W)) dut (
    .i_clock        (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_instr_valid  (instr_valid),
    .i_opcode       (opcode),
    .i_pid_wr       (pid_wr),
    .i_pid_data     (pid_data),
    .i_swap_ack     (swap_ack),
    .o_swap_req     (swap_req),
    .o_swap_cause   (swap_cause),
    .o_current_pid  (current_pid),
    .o_saved_pid    (saved_pid),
    .o_quantum_left (quantum_left),
    .o_swap_count   (swap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = kernel/disarmed, 1 = user slice running, 2 = swap pending.
  int          m_mode;
  int          m_cur, m_saved, m_q, m_cause;
  int unsigned m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_cur <= 0; m_saved <= 0; m_q <= QUANTUM; m_cause <= 0; m_cnt <= 0;
    end else if (m_mode == 2) begin
      if (swap_ack) begin
        m_saved <= m_cur; m_cur <= 0; m_q <= QUANTUM; m_mode <= 0;
        m_cnt <= (m_cnt + 1) % 65536;
      end
    end else if (pid_wr) begin
      m_cur <= int'(pid_data); m_q <= QUANTUM;
      m_mode <= (enable && pid_data != 0) ? 1 : 0;
    end else if (m_mode == 1) begin
      if (!enable) begin
        m_mode <= 0; m_q <= QUANTUM;
      end else if (instr_valid) begin
        if (opcode == 6'b011001) begin
          m_mode <= 2; m_cause <= 1;
        end else if (opcode == 6'b011011) begin
          m_mode <= 2; m_cause <= 2;
        end else begin
          m_q <= m_q - 1;
          if (m_q == 1) begin m_mode <= 2; m_cause <= 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_swap_req", 32'(swap_req), 32'(m_mode == 2));
      check("cyc_cause",    32'(swap_cause), 32'(m_cause));
      check("cyc_cur_pid",  32'(current_pid), 32'(m_cur));
      check("cyc_saved",    32'(saved_pid), 32'(m_saved));
      check("cyc_qleft",    32'(quantum_left), 32'(m_q));
      check("cyc_count",    32'(swap_count), 32'(m_cnt));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_pid(input logic [PID_W-1:0] p);
    pid_wr = 1'b1; pid_data = p;
    cyc();
    pid_wr = 1'b0;
  endtask

  task automatic retire(input logic [5:0] op, input int n);
    instr_valid = 1'b1; opcode = op;
    cyc(n);
    instr_valid = 1'b0; opcode = 6'd0;
  endtask

  task automatic ack();
    swap_ack = 1'b1;
    cyc();
    swap_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; instr_valid = 1'b0; opcode = 6'd0;
    pid_wr = 1'b0; pid_data = '0; swap_ack = 1'b0;
    cyc(2);
    check("rst_qleft", 32'(quantum_left), 32);
    check("rst_req", 32'(swap_req), 0);
    rst_n = 1'b1;
    cyc();

    // Quantum expiry
    enable = 1'b1;
    set_pid(4'd3);
    check("run_pid", 32'(current_pid), 3);
    check("run_q", 32'(quantum_left), 32);
    retire(6'd0, 32);
    check("exp_req", 32'(swap_req), 1);
    check("exp_cause", 32'(swap_cause), 0);
    check("exp_q", 32'(quantum_left), 0);
    pid_wr = 1'b1; pid_data = 4'd9;
    retire(6'd0, 5);
    pid_wr = 1'b0;
    check("hold_req", 32'(swap_req), 1);
    check("hold_pid", 32'(current_pid), 3);
    check("hold_q", 32'(quantum_left), 0);
    ack();
    check("ack_req", 32'(swap_req), 0);
    check("ack_saved", 32'(saved_pid), 3);
    check("ack_cur", 32'(current_pid), 0);
    check("ack_count", 32'(swap_count), 1);
    check("ack_q", 32'(quantum_left), 32);

    // HALT after 9 retires
    set_pid(4'd2);
    retire(6'd0, 9);
    retire(6'b011001, 1);
    check("halt_q", 32'(quantum_left), 23);
    check("halt_req", 32'(swap_req), 1);
    check("halt_cause", 32'(swap_cause), 1);
    cyc(2);
    ack();
    check("halt_count", 32'(swap_count), 2);
    check("halt_saved", 32'(saved_pid), 2);

    // ROUND_ROBIN on the last slot outranks expiry
    set_pid(4'd7);
    retire(6'd5, 31);
    check("rr_q1", 32'(quantum_left), 1);
    retire(6'b011011, 1);
    check("rr_cause", 32'(swap_cause), 2);
    check("rr_q", 32'(quantum_left), 1);
    check("rr_req", 32'(swap_req), 1);
    ack();
    check("rr_count", 32'(swap_count), 3);

    // Ack outside REQ is ignored
    ack();
    check("stray_ack_count", 32'(swap_count), 3);

    // Reload in RUN, with a concurrent retire
    set_pid(4'd4);
    retire(6'd0, 28);
    check("rl_q4", 32'(quantum_left), 4);
    instr_valid = 1'b1;
    set_pid(4'd5);
    instr_valid = 1'b0;
    check("rl_pid", 32'(current_pid), 5);
    check("rl_q", 32'(quantum_left), 32);
    retire(6'd0, 1);
    check("rl_q31", 32'(quantum_left), 31);
    set_pid(4'd0);
    retire(6'd0, 3);
    check("pid0_q", 32'(quantum_left), 32);
    check("pid0_cur", 32'(current_pid), 0);

    // Disarm in RUN
    set_pid(4'd6);
    retire(6'd0, 2);
    check("dis_q30", 32'(quantum_left), 30);
    enable = 1'b0;
    retire(6'd0, 40);
    check("dis_q", 32'(quantum_left), 32);
    check("dis_req", 32'(swap_req), 0);
    check("dis_count", 32'(swap_count), 3);

    // Reset during REQ
    enable = 1'b1;
    set_pid(4'd9);
    retire(6'b011001, 1);
    check("pre_rst_req", 32'(swap_req), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_req", 32'(swap_req), 0);
    check("async_count", 32'(swap_count), 0);
    check("async_cur", 32'(current_pid), 0);
    check("async_q", 32'(quantum_left), 32);
    cyc();
    rst_n = 1'b1;
    ack();
    check("post_rst_req", 32'(swap_req), 0);
    check("post_rst_count", 32'(swap_count), 0);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
